// File: rtl/defines.sv
// Shared defines for the CPU memory path.
//   FULLW         : full machine word width (address and data).
//   RSP_*_ENC     : encodings of the mem_arbiter response-state register.
// Optional build macro consumed elsewhere: MEM_ARB_RR_EN (round-robin arbitration).
`ifndef FULLW
`define FULLW 32
`endif
`ifndef RSP_NONE_ENC
`define RSP_NONE_ENC 2'd0
`endif
`ifndef RSP_IF_ENC
`define RSP_IF_ENC 2'd1
`endif
`ifndef RSP_D_ENC
`define RSP_D_ENC 2'd2
`endif

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM (1-cycle read latency) between the
// instruction-fetch port and the data port of the CPU.
//   clk, nreset            : clock, asynchronous active-low reset
//   if_req/if_addr         : fetch request in;  if_gnt/if_rvalid/if_rdata out
//   d_req/d_we/d_addr/d_wdata : data request in; d_gnt/d_rvalid/d_rdata out
//   mem_ad/mem_d/mem_we    : RAM command out;   mem_q : RAM read data in
//   stall                  : fetch is requesting but was not granted
// Build option: define MEM_ARB_RR_EN for round-robin conflict resolution;
// otherwise the data port always wins a conflict.
`ifndef FULLW
`define FULLW 32
`endif
`ifndef RSP_NONE_ENC
`define RSP_NONE_ENC 2'd0
`endif
`ifndef RSP_IF_ENC
`define RSP_IF_ENC 2'd1
`endif
`ifndef RSP_D_ENC
`define RSP_D_ENC 2'd2
`endif

module mem_arbiter #(
    parameter int AW = `FULLW,
    parameter int DW = `FULLW
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic [AW-1:0] mem_ad,
    output logic [DW-1:0] mem_d,
    output logic          mem_we,
    input  logic [DW-1:0] mem_q,
    output logic          stall
);

    typedef enum logic [1:0] {
        RSP_NONE = `RSP_NONE_ENC,
        RSP_IF   = `RSP_IF_ENC,
        RSP_D    = `RSP_D_ENC
    } rsp_e;

    rsp_e rsp_state_q, rsp_state_d;

`ifdef MEM_ARB_RR_EN
    // 0 = fetch won last, 1 = data won last
    localparam logic WIN_IF = 1'b0;
    localparam logic WIN_D  = 1'b1;
    logic last_winner_q, last_winner_d;
`endif

    // Grant and RAM command; no grant at all while reset is held.
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (nreset) begin
            if (d_req && if_req) begin
`ifdef MEM_ARB_RR_EN
                if (last_winner_q == WIN_IF) d_gnt  = 1'b1;
                else                         if_gnt = 1'b1;
`else
                d_gnt = 1'b1;
`endif
            end else if (d_req) begin
                d_gnt = 1'b1;
            end else if (if_req) begin
                if_gnt = 1'b1;
            end
        end

        mem_ad = '0;
        mem_d  = '0;
        mem_we = 1'b0;
        if (d_gnt) begin
            mem_ad = d_addr;
            if (d_we) begin
                mem_we = 1'b1;
                mem_d  = d_wdata;
            end
        end else if (if_gnt) begin
            mem_ad = if_addr;
        end

        // Response owner for next cycle follows this cycle's grant.
        rsp_state_d = RSP_NONE;
        if (if_gnt)              rsp_state_d = RSP_IF;
        else if (d_gnt && !d_we) rsp_state_d = RSP_D;

`ifdef MEM_ARB_RR_EN
        last_winner_d = last_winner_q;
        if (d_gnt)       last_winner_d = WIN_D;
        else if (if_gnt) last_winner_d = WIN_IF;
`endif
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rsp_state_q <= RSP_NONE;
`ifdef MEM_ARB_RR_EN
            last_winner_q <= WIN_IF;
`endif
        end else begin
            rsp_state_q <= rsp_state_d;
`ifdef MEM_ARB_RR_EN
            last_winner_q <= last_winner_d;
`endif
        end
    end

    assign if_rvalid = (rsp_state_q == RSP_IF);
    assign d_rvalid  = (rsp_state_q == RSP_D);
    assign if_rdata  = if_rvalid ? mem_q : '0;
    assign d_rdata   = d_rvalid  ? mem_q : '0;
    assign stall     = if_req & ~if_gnt;

endmodule
